// File: rtl/count_window_accum.sv
// Sums WINDOW consecutive popcount samples (0..4) into one total held on a valid/ready output.
// Optional running-peak tracking is enabled by defining PEAK_TRACK_EN.
module count_window_accum #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned SUM_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic [2:0]       peak,
  output logic             err
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(4);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               err_q, err_d;

  logic               accept_c;
  logic               emit_c;
  logic               last_c;
  logic               illegal_c;
  logic [CNT_W-1:0]   cnt_clamp_c;
  logic [SUM_W-1:0]   acc_sum_c;

  // Out-of-range samples count as the largest legal value.
  assign illegal_c   = (count > CNT_MAX);
  assign cnt_clamp_c = illegal_c ? CNT_MAX : count;
  assign acc_sum_c   = acc_q + SUM_W'(cnt_clamp_c);

  assign accept_c = in_valid & in_ready;
  assign emit_c   = out_valid & out_ready;
  assign last_c   = (idx_q == IDX_W'(WINDOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (accept_c && last_c) state_d = ST_HOLD;
        ST_HOLD:  if (emit_c)             state_d = ST_ACCUM;
        default:                          state_d = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_HOLD);
  end

  // Window accumulation; sum keeps its last value across clear.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    sum_d = sum_q;
    err_d = err_q;
    if (clear) begin
      acc_d = '0;
      idx_d = '0;
      err_d = 1'b0;
    end else if (accept_c) begin
      if (illegal_c) err_d = 1'b1;
      if (last_c) begin
        sum_d = acc_sum_c;
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = acc_sum_c;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign sum = sum_q;
  assign err = err_q;

`ifdef PEAK_TRACK_EN
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0] max_fin_c;

  // Running max including the sample being accepted this cycle.
  assign max_fin_c = (cnt_clamp_c > max_q) ? cnt_clamp_c : max_q;

  always_comb begin
    max_d  = max_q;
    peak_d = peak_q;
    if (clear) begin
      max_d = '0;
    end else if (accept_c) begin
      if (last_c) begin
        peak_d = max_fin_c;
        max_d  = '0;
      end else begin
        max_d = max_fin_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q  <= '0;
      peak_q <= '0;
    end else begin
      max_q  <= max_d;
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = 3'd0;
`endif

endmodule

// File: tb/tb_count_window_accum.sv
// Directed self-checking bench for count_window_accum (WINDOW=8, SUM_W=6).
module tb_count_window_accum;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned SUM_W  = 6;
`ifdef PEAK_TRACK_EN
  localparam int PK_ON = 1;
`else
  localparam int PK_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       count;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
  logic [2:0]       peak;
  logic             err;

  int n_cmp = 0;
  int n_err = 0;

  count_window_accum #(.WINDOW(WINDOW), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .peak      (peak),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_pk(input int v);
    return (PK_ON != 0) ? v : 0;
  endfunction

  // Present one sample; it is accepted at the following rising edge.
  task automatic send(input logic [2:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    count    = c;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; count = 3'd0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_peak", int'(peak), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);

    // 8 x 4 with consumer ready
    for (int i = 0; i < 8; i++) send(3'd4);
    idle();
    chk("t2_out_valid", int'(out_valid), 1);
    chk("t2_sum", int'(sum), 32);
    chk("t2_peak", int'(peak), exp_pk(4));
    chk("t2_err", int'(err), 0);
    chk("t2_in_ready_hold", int'(in_ready), 0);
    @(negedge clk);
    chk("t2_out_valid_drop", int'(out_valid), 0);
    chk("t2_in_ready_back", int'(in_ready), 1);

    // ramp, consumer stalls 5 cycles; inputs during HOLD must be ignored
    out_ready = 1'b0;
    send(3'd0); send(3'd1); send(3'd2); send(3'd3);
    send(3'd4); send(3'd0); send(3'd1); send(3'd2);
    idle();
    for (int k = 0; k < 5; k++) begin
      chk("t3_out_valid", int'(out_valid), 1);
      chk("t3_sum", int'(sum), 13);
      chk("t3_peak", int'(peak), exp_pk(4));
      chk("t3_in_ready", int'(in_ready), 0);
      in_valid = 1'b1; count = 3'd4;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t3_out_valid_drop", int'(out_valid), 0);
    chk("t3_in_ready_back", int'(in_ready), 1);

    // illegal sample clamps to 4 and sets sticky err
    send(3'd7);
    for (int i = 0; i < 7; i++) send(3'd0);
    idle();
    chk("t4_out_valid", int'(out_valid), 1);
    chk("t4_sum", int'(sum), 4);
    chk("t4_peak", int'(peak), exp_pk(4));
    chk("t4_err", int'(err), 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(3'd1);
    idle();
    chk("t4_sum2", int'(sum), 8);
    chk("t4_peak2", int'(peak), exp_pk(1));
    chk("t4_err_sticky", int'(err), 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t4_err_cleared", int'(err), 0);
    chk("t4_sum_kept", int'(sum), 8);

    // clear discards partial window and the sample presented with it
    for (int i = 0; i < 5; i++) send(3'd3);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; count = 3'd3;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_out_valid_after_clear", int'(out_valid), 0);
    chk("t5_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) send(3'd1);
    idle();
    chk("t5_out_valid", int'(out_valid), 1);
    chk("t5_sum", int'(sum), 8);
    chk("t5_err", int'(err), 0);
    @(negedge clk);

    // in_valid toggled every cycle; then stall in HOLD with input offered
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      count    = 3'd2;
    end
    @(negedge clk);
    chk("t6_out_valid", int'(out_valid), 1);
    chk("t6_sum", int'(sum), 16);
    chk("t6_peak", int'(peak), exp_pk(2));
    in_valid = 1'b1; count = 3'd4;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_ready_hold", int'(in_ready), 0);
    chk("t6_sum_stable", int'(sum), 16);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t6_out_valid_drop", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) send(3'd0);
    idle();
    chk("t6_sum_zero", int'(sum), 0);
    chk("t6_peak_zero", int'(peak), exp_pk(0));
    @(negedge clk);

    // reset asserted mid-cycle after a partial window with err set
    for (int i = 0; i < 8; i++) send(3'd1);
    idle();
    chk("t1_pre_sum", int'(sum), 8);
    @(negedge clk);
    send(3'd5); send(3'd4); send(3'd4);
    idle();
    chk("t1_pre_err", int'(err), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_sum_async", int'(sum), 0);
    chk("t1_err_async", int'(err), 0);
    chk("t1_out_valid_async", int'(out_valid), 0);
    chk("t1_peak_async", int'(peak), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("t1_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) send(3'd1);
    idle();
    chk("t1_sum_no_residue", int'(sum), 8);
    chk("t1_out_valid", int'(out_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
